des_cbc_ctrl: RTL and testbench

DES_CBC_CTRL -- requirements
Module: des_cbc_ctrl

---
 rtl/des_pkg.sv | 19 +
 rtl/des_blk_buf.sv | 34 +++
 rtl/des_cbc_ctrl.sv | 135 +++++++++++++
 tb/tb_des_cbc_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - shared widths and FSM state encoding for the DES CBC controller
package des_pkg;

    localparam int BLK_W  = 64;
    localparam int WORD_W = 32;
    localparam int CNT_W  = 2;

    // Number of bus words that make up one DES block
    localparam logic [CNT_W-1:0] WORD_CNT = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_POST  = 3'd3,
        ST_OUT   = 3'd4
    } state_t;

endpackage

// File: rtl/des_blk_buf.sv
// rtl/des_blk_buf.sv - 2x32 input word buffer assembling one 64-bit DES block
module des_blk_buf
    import des_pkg::*;
(
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              clrptr,
    input  logic              wr_en,
    input  logic [WORD_W-1:0] din,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  in_cnt,
    output logic [BLK_W-1:0]  blk
);

    // First word fills the low half, second the high half; further words are dropped
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            in_cnt <= '0;
            blk    <= '0;
        end else if (!clrptr) begin
            in_cnt <= '0;
            blk    <= '0;
        end else if (clr_cnt) begin
            in_cnt <= '0;
        end else if (wr_en && (in_cnt != WORD_CNT)) begin
            if (in_cnt == '0)
                blk[WORD_W-1:0] <= din;
            else
                blk[BLK_W-1:WORD_W] <= din;
            in_cnt <= in_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/des_cbc_ctrl.sv
// rtl/des_cbc_ctrl.sv - DES ECB/CBC block controller; CBC chaining enabled by DES_CBC_MODE_EN
module des_cbc_ctrl
    import des_pkg::*;
(
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              clrptr,
    input  logic              wr_din,
    input  logic [WORD_W-1:0] din,
    input  logic              cbc_mode,
    input  logic              decrypt,
    input  logic              start,
    input  logic [BLK_W-1:0]  iv_q,
    output logic [BLK_W-1:0]  core_din,
    output logic              core_start,
    input  logic [BLK_W-1:0]  core_dout,
    input  logic              core_done,
    output logic              iv_wr,
    output logic [BLK_W-1:0]  iv_data,
    input  logic              rd_dout,
    output logic [WORD_W-1:0] dout,
    output logic              dout_valid,
    output logic              busy
);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   in_cnt;
    logic [BLK_W-1:0]   blk;
    logic [BLK_W-1:0]   result;
    logic [BLK_W-1:0]   post_res;
    logic               dec_lat;
    logic               rd_ptr;
    logic               cbc_eff;
    logic               start_ok;

    // Start only counts with a full block buffered; in_cnt is the pre-write value
    assign start_ok = start && (state == ST_IDLE) && (in_cnt == WORD_CNT);

    des_blk_buf u_blk_buf (
        .hclk    (hclk),
        .hresetn (hresetn),
        .clrptr  (clrptr),
        .wr_en   (wr_din && (state == ST_IDLE)),
        .din     (din),
        .clr_cnt (start_ok),
        .in_cnt  (in_cnt),
        .blk     (blk)
    );

`ifdef DES_CBC_MODE_EN
    logic             cbc_lat;
    logic [BLK_W-1:0] iv_sav;

    assign cbc_eff = cbc_mode;

    // Chaining mode and the IV in force at start are held for the whole operation
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            cbc_lat <= 1'b0;
            iv_sav  <= '0;
        end else if (!clrptr) begin
            cbc_lat <= 1'b0;
            iv_sav  <= '0;
        end else if (start_ok) begin
            cbc_lat <= cbc_mode;
            iv_sav  <= iv_q;
        end
    end

    assign post_res = (cbc_lat && dec_lat) ? (core_dout ^ iv_sav) : core_dout;
    assign iv_wr    = (state == ST_POST) && cbc_lat;
    assign iv_data  = iv_wr ? (dec_lat ? blk : core_dout) : '0;
`else
    logic unused_ok;

    assign cbc_eff   = 1'b0;
    assign post_res  = core_dout;
    assign iv_wr     = 1'b0;
    assign iv_data   = '0;
    assign unused_ok = ^{cbc_mode, dec_lat};
`endif

    // State register
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn)
            state <= ST_IDLE;
        else if (!clrptr)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic; core_done only matters while waiting on the core
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start_ok) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  if (core_done) state_nxt = ST_POST;
            ST_POST:  state_nxt = ST_OUT;
            ST_OUT:   if (rd_dout && rd_ptr) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Block datapath: core input on start, result in POST, read pointer in OUT
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            dec_lat  <= 1'b0;
            core_din <= '0;
            result   <= '0;
            rd_ptr   <= 1'b0;
        end else if (!clrptr) begin
            dec_lat  <= 1'b0;
            core_din <= '0;
            result   <= '0;
            rd_ptr   <= 1'b0;
        end else begin
            if (start_ok) begin
                dec_lat  <= decrypt;
                core_din <= (cbc_eff && !decrypt) ? (blk ^ iv_q) : blk;
            end
            if (state == ST_POST)
                result <= post_res;
            if ((state == ST_OUT) && rd_dout)
                rd_ptr <= ~rd_ptr;
        end
    end

    assign core_start = (state == ST_ISSUE);
    assign busy       = (state != ST_IDLE);
    assign dout_valid = (state == ST_OUT);
    assign dout       = dout_valid ? (rd_ptr ? result[BLK_W-1:WORD_W] : result[WORD_W-1:0]) : '0;

endmodule

// File: tb/tb_des_cbc_ctrl.sv
// tb/tb_des_cbc_ctrl.sv - self-checking bench for des_cbc_ctrl with a behavioural DES core stand-in
module tb_des_cbc_ctrl;

`ifdef DES_CBC_MODE_EN
    localparam bit CBC_EN = 1'b1;
`else
    localparam bit CBC_EN = 1'b0;
`endif

    logic        hclk = 1'b0;
    logic        hresetn = 1'b0;
    logic        clrptr = 1'b1;
    logic        wr_din = 1'b0;
    logic [31:0] din = '0;
    logic        cbc_mode = 1'b0;
    logic        decrypt = 1'b0;
    logic        start = 1'b0;
    logic [63:0] iv_q = '0;
    logic [63:0] core_din;
    logic        core_start;
    logic [63:0] core_dout = '0;
    logic        core_done = 1'b0;
    logic        iv_wr;
    logic [63:0] iv_data;
    logic        rd_dout = 1'b0;
    logic [31:0] dout;
    logic        dout_valid;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    des_cbc_ctrl dut (
        .hclk       (hclk),
        .hresetn    (hresetn),
        .clrptr     (clrptr),
        .wr_din     (wr_din),
        .din        (din),
        .cbc_mode   (cbc_mode),
        .decrypt    (decrypt),
        .start      (start),
        .iv_q       (iv_q),
        .core_din   (core_din),
        .core_start (core_start),
        .core_dout  (core_dout),
        .core_done  (core_done),
        .iv_wr      (iv_wr),
        .iv_data    (iv_data),
        .rd_dout    (rd_dout),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy)
    );

    always #5 hclk = ~hclk;

    // Stand-in DES core: returns the inverted block core_lat cycles after start
    int          core_lat = 3;
    int          core_cnt = 0;
    logic        core_pend = 1'b0;
    logic [63:0] core_cap = '0;
    logic        force_done = 1'b0;

    always @(posedge hclk) begin
        core_done <= force_done;
        if (core_start) begin
            core_pend <= 1'b1;
            core_cnt  <= core_lat;
            core_cap  <= core_din;
        end else if (core_pend) begin
            if (core_cnt <= 1) begin
                core_pend <= 1'b0;
                core_done <= 1'b1;
                core_dout <= ~core_cap;
            end else begin
                core_cnt <= core_cnt - 1;
            end
        end
    end

    typedef struct {
        logic [31:0] w0;
        logic [31:0] w1;
        logic [63:0] iv;
        bit          cbc;
        bit          dec;
        logic [63:0] cd;
        logic [63:0] res;
        bit          ivw;
        logic [63:0] ivd;
    } vec_t;

    vec_t tbl[3];

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // Reference behaviour from the block's mode rules, with an inverting core
    task automatic model(input logic [63:0] blkv, input logic [63:0] iv, input bit cbc, input bit dec,
                         output logic [63:0] cd, output logic [63:0] res,
                         output bit ivw, output logic [63:0] ivd);
        bit          c;
        logic [63:0] core_out;
        c        = cbc && CBC_EN;
        cd       = (c && !dec) ? (blkv ^ iv) : blkv;
        core_out = ~cd;
        res      = (c && dec) ? (core_out ^ iv) : core_out;
        ivw      = c;
        ivd      = c ? (dec ? blkv : core_out) : 64'd0;
    endtask

    task automatic do_write(input logic [31:0] w);
        wr_din = 1'b1;
        din    = w;
        tick();
        wr_din = 1'b0;
    endtask

    // Waits for the result, checks chaining strobe and both result words
    task automatic finish(input logic [63:0] e_res, input bit e_ivw, input logic [63:0] e_ivd);
        int          n;
        int          nw;
        logic [63:0] ivd;
        n   = 0;
        nw  = 0;
        ivd = '0;
        while (!dout_valid && n < 100) begin
            if (iv_wr) begin
                nw++;
                ivd = iv_data;
            end
            tick();
            n++;
        end
        chk("dout_valid_arrives", 64'(dout_valid), 64'd1);
        chk("iv_wr_pulses", 64'(nw), 64'(e_ivw));
        if (e_ivw)
            chk("iv_data", ivd, e_ivd);
        chk("dout_lo", 64'(dout), 64'(e_res[31:0]));
        rd_dout = 1'b1;
        tick();
        rd_dout = 1'b0;
        chk("dout_hi", 64'(dout), 64'(e_res[63:32]));
        chk("valid_after_rd1", 64'(dout_valid), 64'd1);
        rd_dout = 1'b1;
        tick();
        rd_dout = 1'b0;
        chk("busy_after_rd2", 64'(busy), 64'd0);
        chk("valid_after_rd2", 64'(dout_valid), 64'd0);
    endtask

    task automatic process(input logic [63:0] iv, input bit cbc, input bit dec,
                           input logic [63:0] e_cd, input logic [63:0] e_res,
                           input bit e_ivw, input logic [63:0] e_ivd);
        iv_q     = iv;
        cbc_mode = cbc;
        decrypt  = dec;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        chk("core_start_issue", 64'(core_start), 64'd1);
        chk("core_din", core_din, e_cd);
        tick();
        chk("core_start_one_cycle", 64'(core_start), 64'd0);
        finish(e_res, e_ivw, e_ivd);
    endtask

    initial begin
        logic [63:0] cd, res, ivd, bv;
        bit          ivw;
        int          nw, nv;

        tbl[0] = '{32'h89ABCDEF, 32'h01234567, 64'h0, 1'b0, 1'b0,
                   64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 1'b0, 64'h0};
`ifdef DES_CBC_MODE_EN
        tbl[1] = '{32'h89ABCDEF, 32'h01234567, 64'h1111111111111111, 1'b1, 1'b0,
                   64'h1032547698BADCFE, 64'hEFCDAB8967452301, 1'b1, 64'hEFCDAB8967452301};
        tbl[2] = '{32'h67452301, 32'hEFCDAB89, 64'h1111111111111111, 1'b1, 1'b1,
                   64'hEFCDAB8967452301, 64'h0123456789ABCDEF, 1'b1, 64'hEFCDAB8967452301};
`else
        tbl[1] = '{32'h89ABCDEF, 32'h01234567, 64'h1111111111111111, 1'b1, 1'b0,
                   64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 1'b0, 64'h0};
        tbl[2] = '{32'h67452301, 32'hEFCDAB89, 64'h1111111111111111, 1'b1, 1'b1,
                   64'hEFCDAB8967452301, 64'h1032547698BADCFE, 1'b0, 64'h0};
`endif

        repeat (3) tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_dout_valid", 64'(dout_valid), 64'd0);
        chk("rst_dout", 64'(dout), 64'd0);
        chk("rst_core_din", core_din, 64'd0);
        chk("rst_core_start", 64'(core_start), 64'd0);
        chk("rst_iv_wr", 64'(iv_wr), 64'd0);
        chk("rst_iv_data", iv_data, 64'd0);
        hresetn = 1'b1;
        tick();

        // Directed vectors
        for (int i = 0; i < 3; i++) begin
            do_write(tbl[i].w0);
            do_write(tbl[i].w1);
            process(tbl[i].iv, tbl[i].cbc, tbl[i].dec, tbl[i].cd, tbl[i].res, tbl[i].ivw, tbl[i].ivd);
        end

        // start with only one word buffered is ignored
        do_write(32'hAAAA5555);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_one_word_busy", 64'(busy), 64'd0);
        // third write is dropped; rd_dout in IDLE does not move the read pointer
        do_write(32'h12345678);
        do_write(32'hDEADBEEF);
        rd_dout = 1'b1;
        tick();
        rd_dout = 1'b0;
        process(64'h0, 1'b0, 1'b0, 64'h12345678AAAA5555, ~64'h12345678AAAA5555, 1'b0, 64'h0);

        // start and writes while busy are ignored
        do_write(32'h0BADF00D);
        do_write(32'hCAFEBABE);
        cbc_mode = 1'b0;
        decrypt  = 1'b0;
        start    = 1'b1;
        tick();
        chk("busy_start_core_din", core_din, 64'hCAFEBABE0BADF00D);
        wr_din = 1'b1;
        din    = 32'h55555555;
        tick();
        tick();
        start  = 1'b0;
        wr_din = 1'b0;
        finish(~64'hCAFEBABE0BADF00D, 1'b0, 64'h0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("no_block_after_busy_writes", 64'(busy), 64'd0);

        // clrptr during WAIT, then a late core_done and a spurious one
        core_lat = 10;
        do_write(32'h11223344);
        do_write(32'h55667788);
        iv_q     = 64'h0F0F0F0F0F0F0F0F;
        cbc_mode = 1'b1;
        decrypt  = 1'b0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        clrptr = 1'b0;
        tick();
        clrptr = 1'b1;
        chk("clr_busy", 64'(busy), 64'd0);
        chk("clr_core_din", core_din, 64'd0);
        chk("clr_dout_valid", 64'(dout_valid), 64'd0);
        nw = 0;
        nv = 0;
        for (int i = 0; i < 20; i++) begin
            force_done = (i == 15);
            if (iv_wr) nw++;
            if (dout_valid || busy) nv++;
            tick();
        end
        force_done = 1'b0;
        chk("clr_late_done_iv_wr", 64'(nw), 64'd0);
        chk("clr_late_done_active", 64'(nv), 64'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("clr_in_cnt_start", 64'(busy), 64'd0);

        // Randomized blocks against the reference model
        for (int i = 0; i < 40; i++) begin
            logic [31:0] w0, w1;
            logic [63:0] iv;
            bit          cbc, dec;
            w0       = $urandom;
            w1       = $urandom;
            iv       = {$urandom, $urandom};
            cbc      = 1'($urandom_range(0, 1));
            dec      = 1'($urandom_range(0, 1));
            core_lat = $urandom_range(1, 6);
            bv       = {w1, w0};
            model(bv, iv, cbc, dec, cd, res, ivw, ivd);
            do_write(w0);
            do_write(w1);
            process(iv, cbc, dec, cd, res, ivw, ivd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
